// File: rtl/lsu_bus_unit.sv
// Handshaked load/store unit between the CPU datapath and the data bus bridge.
// Byte-lane shifting, sign/zero extension and optional two-beat misaligned splitting.
module lsu_bus_unit #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [4:0]      req_rd,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic [4:0]      rsp_rd,
  output logic            rsp_err,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic [AW-1:0]   bus_addr,
  output logic            bus_we,
  output logic [DW/8-1:0] bus_wstrb,
  output logic [DW-1:0]   bus_wdata,
  input  logic [DW-1:0]   bus_rdata
);

  localparam int LANES = DW / 8;
  localparam int OW    = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t             state_r;
  logic               we_r;
  logic [1:0]         size_r;
  logic               signed_r;
  logic [OW-1:0]      off_r;
  logic               cross_r;
  logic [DW-1:0]      hi_wdata_r;
  logic [LANES-1:0]   hi_strb_r;
  logic [DW-1:0]      buf_r;

  logic [3:0]         n_s;
  logic [OW-1:0]      off_s;
  logic               mis_s;
  logic               cross_s;
  logic               illegal_s;
  logic [2*DW-1:0]    wide_data_s;
  logic [2*LANES-1:0] strb_base_s;
  logic [2*LANES-1:0] wide_strb_s;
  logic [OW-1:0]      neg_off_s;
  logic [DW-1:0]      lo_rd_s;
  logic [DW-1:0]      hi_rd_s;

  // Keep the low n bytes, then fill the upper bits with the top kept bit or zeros.
  function automatic logic [DW-1:0] extend(input logic [DW-1:0] d, input logic [1:0] sz,
                                           input logic sg);
    logic [DW-1:0] mask;
    logic [6:0]    nbits;
    logic          msb;
    nbits = 7'd8 << sz;
    mask  = ~({DW{1'b1}} << nbits);
    msb   = |(d & (mask ^ (mask >> 1)));
    return (d & mask) | ((sg && msb) ? ~mask : {DW{1'b0}});
  endfunction

  // Request decode and lane alignment of store data, strobes and read data.
  always_comb begin
    n_s         = 4'd1 << req_size;
    off_s       = req_addr[OW-1:0];
    mis_s       = (req_addr[3:0] & (n_s - 4'd1)) != 4'd0;
    cross_s     = ({{(5-OW){1'b0}}, off_s} + {1'b0, n_s}) > 5'(LANES);
    illegal_s   = (req_size == 2'd3) && (DW != 64);
    wide_data_s = {{DW{1'b0}}, req_wdata} << {off_s, 3'b000};
    strb_base_s = ~({(2*LANES){1'b1}} << n_s);
    wide_strb_s = strb_base_s << off_s;
    // Second beat only exists when off > 0, so -off mod LANES equals LANES - off.
    neg_off_s   = ~off_r + OW'(1);
    lo_rd_s     = bus_rdata >> {off_r, 3'b000};
    hi_rd_s     = bus_rdata << {neg_off_s, 3'b000};
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_r    <= IDLE;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= {DW{1'b0}};
      rsp_rd     <= 5'd0;
      rsp_err    <= 1'b0;
      bus_valid  <= 1'b0;
      bus_addr   <= {AW{1'b0}};
      bus_we     <= 1'b0;
      bus_wstrb  <= {LANES{1'b0}};
      bus_wdata  <= {DW{1'b0}};
      we_r       <= 1'b0;
      size_r     <= 2'd0;
      signed_r   <= 1'b0;
      off_r      <= {OW{1'b0}};
      cross_r    <= 1'b0;
      hi_wdata_r <= {DW{1'b0}};
      hi_strb_r  <= {LANES{1'b0}};
      buf_r      <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            we_r       <= req_we;
            size_r     <= req_size;
            signed_r   <= req_signed;
            off_r      <= off_s;
            cross_r    <= cross_s;
            rsp_rd     <= req_rd;
            hi_wdata_r <= req_we ? wide_data_s[2*DW-1:DW] : {DW{1'b0}};
            hi_strb_r  <= req_we ? wide_strb_s[2*LANES-1:LANES] : {LANES{1'b0}};
            if (illegal_s || (mis_s && !SPLIT_MISALIGNED)) begin
              state_r   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= {DW{1'b0}};
            end else begin
              state_r   <= BEAT0;
              rsp_err   <= 1'b0;
              bus_valid <= 1'b1;
              bus_addr  <= {req_addr[AW-1:OW], {OW{1'b0}}};
              bus_we    <= req_we;
              bus_wstrb <= req_we ? wide_strb_s[LANES-1:0] : {LANES{1'b0}};
              bus_wdata <= req_we ? wide_data_s[DW-1:0] : {DW{1'b0}};
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        BEAT0: begin
          if (bus_ready) begin
            if (cross_r) begin
              state_r   <= BEAT1;
              bus_addr  <= bus_addr + AW'(LANES);
              bus_wstrb <= hi_strb_r;
              bus_wdata <= hi_wdata_r;
              buf_r     <= lo_rd_s;
            end else begin
              state_r   <= RESP;
              bus_valid <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_rdata <= we_r ? {DW{1'b0}} : extend(lo_rd_s, size_r, signed_r);
            end
          end
        end
        BEAT1: begin
          if (bus_ready) begin
            state_r   <= RESP;
            bus_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= we_r ? {DW{1'b0}} : extend(buf_r | hi_rd_s, size_r, signed_r);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r   <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          bus_valid <= 1'b0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_unit.sv
// Directed bench for lsu_bus_unit: one splitting instance (u0) and one rejecting instance (u1).
module tb_lsu_bus_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, e_req_valid = 1'b0;
  logic        req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        rsp_ready = 1'b1, e_rsp_ready = 1'b1;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  logic        req_ready, rsp_valid, rsp_err, bus_valid, bus_we;
  logic [31:0] rsp_rdata, bus_addr, bus_wdata;
  logic [4:0]  rsp_rd;
  logic [3:0]  bus_wstrb;

  logic        e_req_ready, e_rsp_valid, e_rsp_err, e_bus_valid, e_bus_we;
  logic [31:0] e_rsp_rdata, e_bus_addr, e_bus_wdata;
  logic [4:0]  e_rsp_rd;
  logic [3:0]  e_bus_wstrb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lsu_bus_unit u0 (
    .cpu_clk(clk), .cpu_rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd),
    .rsp_err(rsp_err), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  lsu_bus_unit #(.SPLIT_MISALIGNED(1'b0)) u1 (
    .cpu_clk(clk), .cpu_rst_n(rst_n),
    .req_valid(e_req_valid), .req_ready(e_req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(e_rsp_valid), .rsp_ready(e_rsp_ready), .rsp_rdata(e_rsp_rdata),
    .rsp_rd(e_rsp_rd), .rsp_err(e_rsp_err), .bus_valid(e_bus_valid), .bus_ready(bus_ready),
    .bus_addr(e_bus_addr), .bus_we(e_bus_we), .bus_wstrb(e_bus_wstrb),
    .bus_wdata(e_bus_wdata), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    req_we = we; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd; req_rd = rd;
  endtask

  // Present a request to u0 for one edge; it is accepted at that edge (edge N).
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    setup(we, sz, sg, addr, wd, rd);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_wstrb", bus_wstrb, 4'h0);
    rst_n = 1'b1;
    step();
    chk("req_ready_after_rst", req_ready, 1'b1);

    // Aligned word load, zero-wait bus
    bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
    issue(1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'h0, 5'd7);
    chk("wl_bus_valid", bus_valid, 1'b1);
    chk("wl_bus_addr", bus_addr, 32'h1000_0004);
    chk("wl_wstrb", bus_wstrb, 4'b0000);
    chk("wl_req_ready", req_ready, 1'b0);
    chk("wl_rsp_early", rsp_valid, 1'b0);
    step();
    chk("wl_rsp_valid", rsp_valid, 1'b1);
    chk("wl_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("wl_err", rsp_err, 1'b0);
    chk("wl_rd", rsp_rd, 5'd7);
    chk("wl_bus_idle", bus_valid, 1'b0);
    step();
    chk("wl_rsp_done", rsp_valid, 1'b0);
    chk("wl_req_ready_back", req_ready, 1'b1);

    // Byte loads, signed and unsigned
    bus_rdata = 32'h80112233;
    issue(1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'h0, 5'd3);
    chk("bl_bus_addr", bus_addr, 32'h0);
    step();
    chk("bl_signed", rsp_rdata, 32'hFFFF_FF80);
    step();
    issue(1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'h0, 5'd4);
    step();
    chk("bl_unsigned", rsp_rdata, 32'h0000_0080);
    chk("bl_rd", rsp_rd, 5'd4);
    step();

    // Half store
    issue(1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h0000_ABCD, 5'd9);
    chk("hs_wstrb", bus_wstrb, 4'b1100);
    chk("hs_wdata", bus_wdata, 32'hABCD_0000);
    chk("hs_we", bus_we, 1'b1);
    chk("hs_addr", bus_addr, 32'h0);
    step();
    chk("hs_rsp_valid", rsp_valid, 1'b1);
    chk("hs_rdata", rsp_rdata, 32'h0);
    step();

    // Split word load with a 3-cycle wait on the first beat
    bus_ready = 1'b0; bus_rdata = 32'h0;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0003, 32'h0, 5'd12);
    for (int i = 0; i < 3; i++) begin
      chk("sp_hold_valid", bus_valid, 1'b1);
      chk("sp_hold_addr", bus_addr, 32'h0);
      chk("sp_hold_we", bus_we, 1'b0);
      chk("sp_hold_wstrb", bus_wstrb, 4'b0000);
      chk("sp_no_rsp", rsp_valid, 1'b0);
      step();
    end
    bus_rdata = 32'h44332211; bus_ready = 1'b1;
    step();
    chk("sp_beat1_valid", bus_valid, 1'b1);
    chk("sp_beat1_addr", bus_addr, 32'h0000_0004);
    chk("sp_beat1_no_rsp", rsp_valid, 1'b0);
    bus_rdata = 32'h88776655;
    step();
    chk("sp_rsp_valid", rsp_valid, 1'b1);
    chk("sp_rdata", rsp_rdata, 32'h7766_5544);
    chk("sp_bus_idle", bus_valid, 1'b0);
    step();

    // Split at the top of the address space, zero-wait: rsp at N+3
    bus_rdata = 32'h44332211;
    issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd13);
    chk("wr_beat0_addr", bus_addr, 32'hFFFF_FFFC);
    step();
    chk("wr_beat1_addr", bus_addr, 32'h0000_0000);
    chk("wr_beat1_valid", bus_valid, 1'b1);
    chk("wr_no_rsp", rsp_valid, 1'b0);
    step();
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_rdata", rsp_rdata, 32'h3322_1144);
    step();

    // Illegal size on the splitting instance
    issue(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 5'd14);
    chk("sz3_bus_valid", bus_valid, 1'b0);
    chk("sz3_rsp_valid", rsp_valid, 1'b1);
    chk("sz3_err", rsp_err, 1'b1);
    step();

    // Rejecting instance: misaligned word load and illegal size
    setup(1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0, 5'd21);
    e_req_valid = 1'b1;
    step();
    e_req_valid = 1'b0;
    chk("mis_bus_valid", e_bus_valid, 1'b0);
    chk("mis_rsp_valid", e_rsp_valid, 1'b1);
    chk("mis_err", e_rsp_err, 1'b1);
    chk("mis_rdata", e_rsp_rdata, 32'h0);
    chk("mis_rd", e_rsp_rd, 5'd21);
    step();
    chk("mis_rsp_done", e_rsp_valid, 1'b0);
    chk("mis_bus_never", e_bus_valid, 1'b0);
    step();
    setup(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 5'd22);
    e_req_valid = 1'b1;
    step();
    e_req_valid = 1'b0;
    chk("e_sz3_bus_valid", e_bus_valid, 1'b0);
    chk("e_sz3_rsp_valid", e_rsp_valid, 1'b1);
    chk("e_sz3_err", e_rsp_err, 1'b1);
    chk("e_sz3_rdata", e_rsp_rdata, 32'h0);
    step();

    // Response back-pressure for 4 cycles
    rsp_ready = 1'b0; bus_rdata = 32'h12345678;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0, 5'd17);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_rdata", rsp_rdata, 32'h12345678);
      chk("bp_rd", rsp_rd, 5'd17);
      chk("bp_err", rsp_err, 1'b0);
      chk("bp_req_ready", req_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_done", rsp_valid, 1'b0);
    step();

    // Reset during a BEAT0 wait
    bus_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 5'd18);
    chk("mr_bus_valid", bus_valid, 1'b1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_bus_drop", bus_valid, 1'b0);
    chk("mr_addr_clr", bus_addr, 32'h0);
    chk("mr_req_ready", req_ready, 1'b0);
    chk("mr_rsp_valid", rsp_valid, 1'b0);
    bus_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("mr_req_ready_back", req_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("mr_no_rsp", rsp_valid, 1'b0);
      chk("mr_no_bus", bus_valid, 1'b0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_bus_unit.md
# lsu_bus_unit

Parametrised, handshaked load/store unit between the CPU datapath and the data bus bridge. It supersedes the purely combinational byte-lane load/store logic:
- supports variable-latency bus slaves through a valid/ready handshake;
- takes a configurable data width;
- performs byte/half/word(/dword) accesses with sign or zero extension;
- can either split misaligned accesses into two bus beats or reject them with an error response.

## Interface
Parameters:
- DW, 32: data width, 32 or 64; lanes = DW/8, little-endian.
- AW, 32: address width.
- SPLIT_MISALIGNED, 1: 1 = misaligned accesses are split into two beats where needed; 0 = misaligned accesses return an error.

Ports (one clock; reset is asynchronous and active-low):
- cpu_clk  in  1  clock, rising edge.
- cpu_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit accepts a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DW=64).
- req_signed  in  1  sign-extend load result.
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, right-aligned.
- req_rd  in  5  destination register tag, returned unchanged.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  DW  load result, extended; 0 for stores and errors.
- rsp_rd  out  5  tag of the request.
- rsp_err  out  1  misaligned (SPLIT_MISALIGNED=0) or illegal size.
- bus_valid  out  1  bus beat pending.
- bus_ready  in  1  beat completes this cycle; bus_rdata is valid in the same cycle.
- bus_addr  out  AW  lane-aligned address (low log2(DW/8) bits are 0).
- bus_we  out  1  write beat.
- bus_wstrb  out  DW/8  byte write enables; all 0 for reads.
- bus_wdata  out  DW  lane-shifted store data.
- bus_rdata  in  DW  read data.

## Operation
- States: IDLE, BEAT0, BEAT1, RESP. `req_ready` is 1 only in IDLE.
- Accept: on `req_valid && req_ready`, register all request fields and compute:
  - n = 1 << req_size;
  - off = addr mod (DW/8);
  - mis = addr mod n != 0;
  - cross = off + n > DW/8.
- IDLE transitions after accept:
  - illegal size, or (mis and SPLIT_MISALIGNED=0) → RESP with `rsp_err`=1 and no bus activity;
  - otherwise → BEAT0.
- BEAT0:
  - `bus_addr` = addr & ~(DW/8−1).
  - Lanes off..min(off+n, DW/8)−1 carry the low bytes.
  - On `bus_ready`: → BEAT1 if cross, else → RESP.
- BEAT1:
  - `bus_addr` = BEAT0 address + DW/8, computed modulo 2^AW (wraps to 0 at the top of the address space).
  - Lanes 0..(off+n−DW/8−1) carry the remaining bytes.
  - On `bus_ready`: → RESP.
- Loads: bytes are captured from `bus_rdata` on each completing beat and assembled low→high. The result is sign-extended from bit 8n−1 if `req_signed`, otherwise zero-extended.
- Stores: `bus_wdata` = `req_wdata` shifted so that byte i lands on its address lane; `bus_wstrb` covers exactly the bytes of that beat.
- RESP: `rsp_valid`=1 with `rsp_rd`, `rsp_rdata` and `rsp_err` stable; on `rsp_ready` → IDLE.
- Exactly one response is produced per accepted request.

## Timing
- All outputs are registered.
- Reset values: `req_ready` 0, `rsp_valid` 0, `rsp_rdata` 0, `rsp_rd` 0, `rsp_err` 0, `bus_valid` 0, `bus_addr` 0, `bus_we` 0, `bus_wstrb` 0, `bus_wdata` 0; state IDLE.
- `req_ready` rises on the first `cpu_clk` edge after `cpu_rst_n` deasserts.
- Accept at edge N: `bus_valid`=1 from cycle N+1.
  - `bus_valid`, `bus_addr`, `bus_we`, `bus_wstrb` and `bus_wdata` are held stable until the cycle in which `bus_ready`=1.
  - For a two-beat access, `bus_valid` stays 1 between beats.
- Minimum latency with zero-wait bus:
  - single beat: `rsp_valid` at N+2;
  - split: `rsp_valid` at N+3;
  - error: `rsp_valid` at N+1.
- `rsp_valid` is held until `rsp_ready`. `req_ready` returns on the cycle after the response handshake.
- `bus_ready` is ignored while `bus_valid`=0.
- `req_valid` is ignored outside IDLE, i.e. a new request is not accepted in the cycle its predecessor's response is taken.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronously, including `bus_valid`). The in-flight request is discarded and produces no response.

## Test plan
- Aligned word load, DW=32, addr 0x1000_0004, `bus_ready`=1 at once, `bus_rdata` 0xDEADBEEF → `bus_addr` 0x1000_0004, `bus_wstrb` 0000, `rsp_rdata` 0xDEADBEEF at N+2, `rsp_err` 0.
- Byte load, addr 0x0000_0003, `bus_rdata` 0x80112233 → `req_signed`=1 gives 0xFFFF_FF80; `req_signed`=0 gives 0x0000_0080.
- Half store, addr 0x0000_0002, `req_wdata` 0x0000_ABCD → `bus_wstrb` 1100, `bus_wdata` 0xABCD_0000, `bus_we` 1, `rsp_rdata` 0.
- SPLIT_MISALIGNED=1 word load at addr 0x0000_0003, `bus_ready` delayed 3 cycles on BEAT0 (beat1 data 0x88776655 at `bus_addr` 0x4, beat0 data 0x44332211 at `bus_addr` 0x0) → outputs held stable during the delay; `rsp_rdata` 0x7766_5544. Repeat at addr 0xFFFF_FFFF → beat1 `bus_addr` 0x0000_0000.
- SPLIT_MISALIGNED=0 word load at addr 0x0000_0002 → `bus_valid` never asserts; `rsp_valid` at N+1 with `rsp_err` 1 and `rsp_rdata` 0. Same error response for `req_size`=3 with DW=32.
- Hold `rsp_ready`=0 for 4 cycles, then assert `cpu_rst_n`=0 during a BEAT0 wait on a later request → response held stable for the 4 cycles; after the reset, `bus_valid` drops in the same cycle, no `rsp_valid` appears, and `req_ready`=1 one edge after reset release.
